// File: rtl/axi_lite_master_if.sv
// Register-bus channels (AW, W, write response, AR, R) between the
// initiator and the register-bank slave.
interface axi_lite_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [DATA_WIDTH-1:0] rData;
    logic                  rvalid;

    modport master (
        output awvalid, awaddr, wvalid, wdata, arvalid, araddr,
        input  awready, wready, wresp, arready, rData, rvalid
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, arvalid, araddr,
        output awready, wready, wresp, arready, rData, rvalid
    );
endinterface

// File: rtl/axi_lite_master.sv
// Register-bus initiator: one write or read command at a time, single-cycle completion pulse.
// Define AXI_LITE_MASTER_TIMEOUT_EN to build the per-phase timeout abort (rsp_err).
module axi_lite_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    axi_lite_master_if.master     bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    state_t                state, state_nxt;

    logic                  cmd_ready_r, cmd_ready_nxt;
    logic                  rsp_valid_r, rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] rsp_rdata_r, rsp_rdata_nxt;
    logic                  awvalid_r,   awvalid_nxt;
    logic [ADDR_WIDTH-1:0] awaddr_r,    awaddr_nxt;
    logic                  wvalid_r,    wvalid_nxt;
    logic [DATA_WIDTH-1:0] wdata_r,     wdata_nxt;
    logic                  arvalid_r,   arvalid_nxt;
    logic [ADDR_WIDTH-1:0] araddr_r,    araddr_nxt;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]      tmo_cnt, tmo_cnt_nxt;
    logic                  rsp_err_r, rsp_err_nxt;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            awvalid_r   <= 1'b0;
            awaddr_r    <= '0;
            wvalid_r    <= 1'b0;
            wdata_r     <= '0;
            arvalid_r   <= 1'b0;
            araddr_r    <= '0;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
            tmo_cnt     <= '0;
            rsp_err_r   <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            cmd_ready_r <= cmd_ready_nxt;
            rsp_valid_r <= rsp_valid_nxt;
            rsp_rdata_r <= rsp_rdata_nxt;
            awvalid_r   <= awvalid_nxt;
            awaddr_r    <= awaddr_nxt;
            wvalid_r    <= wvalid_nxt;
            wdata_r     <= wdata_nxt;
            arvalid_r   <= arvalid_nxt;
            araddr_r    <= araddr_nxt;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
            tmo_cnt     <= tmo_cnt_nxt;
            rsp_err_r   <= rsp_err_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata_r;
        awvalid_nxt   = awvalid_r;
        awaddr_nxt    = awaddr_r;
        wvalid_nxt    = wvalid_r;
        wdata_nxt     = wdata_r;
        arvalid_nxt   = arvalid_r;
        araddr_nxt    = araddr_r;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        rsp_err_nxt   = 1'b0;
        tmo_cnt_nxt   = tmo_cnt;
`endif

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        state_nxt   = WR_REQ;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        awaddr_nxt  = cmd_addr;
                        wdata_nxt   = cmd_wdata;
                    end else begin
                        state_nxt   = RD_REQ;
                        arvalid_nxt = 1'b1;
                        araddr_nxt  = cmd_addr;
                    end
                end
            end
            WR_REQ: begin
                // AW and W retire independently; the phase ends once neither is pending.
                if (bus.awready) awvalid_nxt = 1'b0;
                if (bus.wready)  wvalid_nxt  = 1'b0;
                if ((!awvalid_r || bus.awready) && (!wvalid_r || bus.wready))
                    state_nxt = WR_RESP;
            end
            WR_RESP: begin
                if (bus.wresp) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = '0;
                end
            end
            RD_REQ: begin
                if (bus.arready) begin
                    state_nxt   = RD_DATA;
                    arvalid_nxt = 1'b0;
                end
            end
            RD_DATA: begin
                if (bus.rvalid) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = bus.rData;
                end
            end
            default: state_nxt = IDLE;
        endcase

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        // Abort only when the phase is stalled; any progress (including completion) wins.
        if ((state != IDLE) && (state_nxt == state) &&
            (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            state_nxt     = IDLE;
            awvalid_nxt   = 1'b0;
            wvalid_nxt    = 1'b0;
            arvalid_nxt   = 1'b0;
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
            rsp_rdata_nxt = '0;
        end

        if (state_nxt != state)
            tmo_cnt_nxt = '0;
        else if (state != IDLE)
            tmo_cnt_nxt = tmo_cnt + 1'b1;
`endif

        // Ready in the completion cycle so a new command can be taken immediately.
        cmd_ready_nxt = (state_nxt == IDLE);
    end

    assign cmd_ready   = cmd_ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign bus.awvalid = awvalid_r;
    assign bus.awaddr  = awaddr_r;
    assign bus.wvalid  = wvalid_r;
    assign bus.wdata   = wdata_r;
    assign bus.arvalid = arvalid_r;
    assign bus.araddr  = araddr_r;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    assign rsp_err = rsp_err_r;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: directed vector table, hand sequences for
// back-to-back, reset and stall cases, then randomized transactions against a phase model.
module tb_axi_lite_master;

    localparam int DW     = 32;
    localparam int AW     = 2;
    localparam int TMO    = 16;
    localparam int BUDGET = 64;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    axi_lite_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    axi_lite_master #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            aw_d;
        int            w_d;
        int            b_d;
        int            ar_d;
        int            r_d;
        bit            early;   // wresp / rvalid held high from the first cycle
        logic [DW-1:0] rdata;
        int            exp_lat;
        logic [DW-1:0] exp_rd;
    } vec_t;

    int            ncmp;
    int            nfail;
    logic [DW-1:0] last_rdata;
    vec_t          tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input int aw_d, input int w_d, input int b_d,
                                input int ar_d, input int r_d, input bit early,
                                input logic [DW-1:0] rd, input int lat, input logic [DW-1:0] erd);
        vec_t v;
        v.write = wr; v.addr = a; v.data = d;
        v.aw_d = aw_d; v.w_d = w_d; v.b_d = b_d; v.ar_d = ar_d; v.r_d = r_d;
        v.early = early; v.rdata = rd; v.exp_lat = lat; v.exp_rd = erd;
        return v;
    endfunction

    // Latency = issue cycle + waiting for readies + first response-phase cycle
    //           + waiting for the slave's answer + the registered completion cycle.
    function automatic int model_latency(input vec_t v);
        int addr_wait;
        if (v.write) begin
            addr_wait = (v.aw_d > v.w_d) ? v.aw_d : v.w_d;
            return 1 + addr_wait + 1 + (v.early ? 0 : v.b_d) + 1;
        end
        return 1 + v.ar_d + 1 + (v.early ? 0 : v.r_d) + 1;
    endfunction

    task automatic clear_slave();
        bus.awready = 1'b0; bus.wready = 1'b0; bus.wresp = 1'b0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rData = '0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_err"},   rsp_err,   0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_valids"},    {bus.awvalid, bus.wvalid, bus.arvalid}, 0);
        chk({tag, "_addrs"},     {bus.awaddr, bus.araddr}, 0);
        chk({tag, "_wdata"},     bus.wdata, 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("idle_rsp_valid", rsp_valid, 0);
            chk("idle_cmd_ready", cmd_ready, 1);
            chk("idle_rdata_hold", rsp_rdata, last_rdata);
            chk("idle_valids", {bus.awvalid, bus.wvalid, bus.arvalid}, 0);
        end
    endtask

    // Entered and left at a falling edge; the slave answers on a fixed per-command schedule.
    task automatic run_txn(input string tag, input vec_t v, input bit hold);
        int lat, aw_hi, w_hi, ar_hi, bad_stab, bad_cross, bad_rdy, addr_wait;
        lat = 0; aw_hi = 0; w_hi = 0; ar_hi = 0; bad_stab = 0; bad_cross = 0; bad_rdy = 0;
        addr_wait = (v.aw_d > v.w_d) ? v.aw_d : v.w_d;
        chk({tag, "_accept_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.data;
        for (int c = 1; c <= BUDGET; c++) begin
            @(negedge clk);
            if (!hold) cmd_valid = 1'b0;
            if (rsp_valid) begin
                lat = c;
                break;
            end
            if (cmd_ready) bad_rdy++;
            if (bus.awvalid) begin aw_hi++; if (bus.awaddr !== v.addr) bad_stab++; end
            if (bus.wvalid)  begin w_hi++;  if (bus.wdata  !== v.data) bad_stab++; end
            if (bus.arvalid) begin ar_hi++; if (bus.araddr !== v.addr) bad_stab++; end
            if (v.write ? bus.arvalid : (bus.awvalid || bus.wvalid)) bad_cross++;
            bus.awready = v.write && (c == 1 + v.aw_d);
            bus.wready  = v.write && (c == 1 + v.w_d);
            bus.wresp   = v.write && (v.early || (c == 2 + addr_wait + v.b_d));
            bus.arready = !v.write && (c == 1 + v.ar_d);
            bus.rvalid  = !v.write && (v.early || (c == 2 + v.ar_d + v.r_d));
            bus.rData   = bus.rvalid ? v.rdata : DW'($urandom);
        end
        chk({tag, "_latency"}, lat, v.exp_lat);
        if (lat != 0) begin
            chk({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rd);
            chk({tag, "_rsp_err"}, rsp_err, 0);
            chk({tag, "_ready_at_rsp"}, cmd_ready, 1);
        end
        chk({tag, "_busy_ready_low"}, bad_rdy, 0);
        chk({tag, "_stable_addr_data"}, bad_stab, 0);
        chk({tag, "_no_channel_overlap"}, bad_cross, 0);
        if (v.write) begin
            chk({tag, "_awvalid_cycles"}, aw_hi, v.aw_d + 1);
            chk({tag, "_wvalid_cycles"},  w_hi,  v.w_d + 1);
        end else begin
            chk({tag, "_arvalid_cycles"}, ar_hi, v.ar_d + 1);
        end
        last_rdata = v.exp_rd;
        clear_slave();
        if (!hold) cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ar_hi, rsp_n, rsp_at, bad;
        vec_t v, v2;
        ncmp = 0; nfail = 0; last_rdata = '0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        clear_slave();

        tbl[0] = mk(1, 2'd2, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 32'h0,        3, 32'h0);
        tbl[1] = mk(1, 2'd3, 32'h12345678, 0, 4, 1, 0, 0, 0, 32'h0,        8, 32'h0);
        tbl[2] = mk(0, 2'd1, 32'h0,        0, 0, 0, 2, 3, 0, 32'hA5A5A5A5, 8, 32'hA5A5A5A5);
        tbl[3] = mk(0, 2'd0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h01234567, 3, 32'h01234567);
        tbl[4] = mk(1, 2'd1, 32'h0F0F0F0F, 3, 1, 2, 0, 0, 0, 32'h0,        8, 32'h0);
        tbl[5] = mk(1, 2'd2, 32'h55AA55AA, 2, 0, 0, 0, 0, 1, 32'h0,        5, 32'h0);
        tbl[6] = mk(0, 2'd3, 32'h0,        0, 0, 0, 4, 0, 1, 32'h5A5A0001, 7, 32'h5A5A0001);
        tbl[7] = mk(1, 2'd0, 32'hFFFFFFFF, 4, 4, 0, 0, 0, 0, 32'h0,        7, 32'h0);

        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        idle(1);

        for (int i = 0; i < 8; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i], 1'b0);
            idle(1);
        end

        // Back-to-back: write with cmd_valid held, read accepted in the write's completion cycle.
        v  = mk(1, 2'd3, 32'h11112222, 1, 0, 0, 0, 0, 0, 32'h0,        4, 32'h0);
        v2 = mk(0, 2'd2, 32'h0,        0, 0, 0, 0, 1, 0, 32'h600DF00D, 4, 32'h600DF00D);
        run_txn("b2b_wr", v, 1'b1);
        run_txn("b2b_rd", v2, 1'b0);
        idle(1);

        // Reset while waiting for the write response.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd2; cmd_wdata = 32'hCAFE0001;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rst_wr_awvalid", bus.awvalid, 1);
        bus.awready = 1'b1; bus.wready = 1'b1;
        @(negedge clk);
        clear_slave();
        @(negedge clk);
        chk("rst_wr_in_resp_busy", cmd_ready, 0);
        rst = 1'b1;
        #1;
        check_reset_values("rst_wr_resp");
        bus.wresp = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_rdata = '0;
        idle(3);
        clear_slave();

        // Reset while the read address is outstanding.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rst_rd_arvalid", bus.arvalid, 1);
        rst = 1'b1;
        #1;
        check_reset_values("rst_rd_req");
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Slave never accepts the read address.
        chk("stall_accept_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd1;
        ar_hi = 0; rsp_n = 0; rsp_at = 0; bad = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (bus.arvalid) begin ar_hi++; if (bus.araddr !== 2'd1) bad++; end
            if (rsp_valid) begin
                rsp_n++;
                if (rsp_at == 0) rsp_at = c;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
                chk("tmo_rsp_err", rsp_err, 1);
                chk("tmo_rsp_rdata", rsp_rdata, 0);
`endif
            end
        end
        chk("stall_araddr_stable", bad, 0);
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        chk("tmo_arvalid_cycles", ar_hi, TMO);
        chk("tmo_rsp_count", rsp_n, 1);
        chk("tmo_rsp_cycle", rsp_at, TMO + 1);
        last_rdata = '0;
        idle(1);
`else
        chk("stall_arvalid_cycles", ar_hi, 40);
        chk("stall_rsp_count", rsp_n, 0);
        chk("stall_rsp_at", rsp_at, 0);
        rst = 1'b1;
        #1;
        chk("stall_rst_arvalid", bus.arvalid, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
`endif

        // Randomized traffic checked against the phase model.
        for (int i = 0; i < 40; i++) begin
            int  gap;
            bit  hold;
            gap  = $urandom_range(0, 2);
            hold = (gap == 0) && (i < 39) && ($urandom_range(0, 1) == 1);
            v.write = ($urandom_range(0, 1) == 1);
            v.addr  = AW'($urandom_range(0, 3));
            v.data  = DW'($urandom);
            v.aw_d  = $urandom_range(0, 4);
            v.w_d   = $urandom_range(0, 4);
            v.b_d   = $urandom_range(0, 4);
            v.ar_d  = $urandom_range(0, 4);
            v.r_d   = $urandom_range(0, 4);
            v.early = ($urandom_range(0, 3) == 0);
            v.rdata = DW'($urandom);
            v.exp_lat = model_latency(v);
            v.exp_rd  = v.write ? '0 : v.rdata;
            run_txn($sformatf("rnd%0d", i), v, hold);
            if (gap > 0) idle(gap);
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
